instr_mem_fetch: RTL and testbench

- Parametrised, clocked successor to the combinational instruction ROM.
- Word-addressed instruction store with a program-load write port, a one-cycle registered fetch path with valid/ready handshake, and a flush input for taken branches.
- Sits between the fetch stage (PC source) and the decode stage. It replaces hard-coded contents with contents loaded at run time.

---
 rtl/instr_mem_fetch.sv | 114 +++++++++++
 tb/tb_instr_mem_fetch.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_fetch.sv
// Run-time loadable instruction store with a one-cycle registered fetch path, valid/ready handshake and flush.
// Optional macro IMEM_FAULT_EN adds rsp_fault for out-of-range or misaligned fetches.
module instr_mem_fetch #(
    parameter int                 DATA_W   = 22,
    parameter int                 ADDR_W   = 22,
    parameter int                 DEPTH    = 128,
    parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_done,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    input  logic              rsp_ready,
    input  logic              flush,
    output logic              running
`ifdef IMEM_FAULT_EN
    ,
    output logic              rsp_fault
`endif
);

    localparam int IDX_W  = ADDR_W - 2;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH);

    typedef enum logic {S_LOAD, S_RUN} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  req_idx;
    logic [IDX_W-1:0]  load_idx;
    logic              req_in_range;
    logic              load_in_range;
    logic              accept;
    logic              fetch_bad;
    logic [DATA_W-1:0] fetch_word;
    logic              unused_bits;

    assign req_idx       = req_addr[ADDR_W-1:2];
    assign load_idx      = load_addr[ADDR_W-1:2];
    assign req_in_range  = {1'b0, req_idx} < DEPTH_L;
    assign load_in_range = {1'b0, load_idx} < DEPTH_L;

    // Flush frees the output slot regardless of the consumer, so a new fetch can issue alongside it.
    assign req_ready = running & (flush | ~rsp_valid | rsp_ready);
    assign accept    = req_valid & req_ready;

`ifdef IMEM_FAULT_EN
    assign fetch_bad   = ~req_in_range | (req_addr[1:0] != 2'b00);
    assign unused_bits = ^load_addr[1:0];
`else
    assign fetch_bad   = ~req_in_range;
    assign unused_bits = ^{load_addr[1:0], req_addr[1:0]};
`endif

    always_comb begin
        fetch_word = NOP_WORD;
        if (!fetch_bad)
            fetch_word = mem[req_idx[MEM_AW-1:0]];
    end

    // Nonblocking write: a same-edge fetch of this index still sees the old word.
    always_ff @(posedge clk) begin
        if (load_we && load_in_range)
            mem[load_idx[MEM_AW-1:0]] <= load_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_LOAD;
            running   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= NOP_WORD;
            rsp_addr  <= '0;
`ifdef IMEM_FAULT_EN
            rsp_fault <= 1'b0;
`endif
        end else begin
            case (state)
                S_LOAD: begin
                    if (load_done) begin
                        state   <= S_RUN;
                        running <= 1'b1;
                    end
                end
                default: begin
                    state   <= S_RUN;
                    running <= 1'b1;
                end
            endcase

            if (accept) begin
                rsp_valid <= 1'b1;
                rsp_addr  <= req_addr;
                rsp_data  <= fetch_word;
`ifdef IMEM_FAULT_EN
                rsp_fault <= fetch_bad;
`endif
            end else if (flush || rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Directed bench for instr_mem_fetch: a scoreboard queue holds expected responses from each accepted fetch.
module tb_instr_mem_fetch;

    localparam int                DATA_W = 22;
    localparam int                ADDR_W = 22;
    localparam int                DEPTH  = 128;
    localparam logic [DATA_W-1:0] NOP    = '0;
    localparam logic [DATA_W-1:0] WORD0  = 22'b1001101000000110000000;
    localparam logic [DATA_W-1:0] WORD1  = 22'b1001101000000010000000;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_data;
    logic              load_done;
    logic              req_valid;
    logic [ADDR_W-1:0] req_addr;
    logic              req_ready;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_ready;
    logic              flush;
    logic              running;
`ifdef IMEM_FAULT_EN
    logic              rsp_fault;
`endif

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              bad;
    } rsp_t;

    rsp_t              sb[$];
    logic [DATA_W-1:0] model [DEPTH];
    int                errors = 0;
    int                checks = 0;

    instr_mem_fetch #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NOP_WORD(NOP)
    ) dut (
        .clk(clk), .rst(rst),
        .load_we(load_we), .load_addr(load_addr), .load_data(load_data), .load_done(load_done),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_addr(rsp_addr), .rsp_ready(rsp_ready),
        .flush(flush), .running(running)
`ifdef IMEM_FAULT_EN
        , .rsp_fault(rsp_fault)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rsp_t expect_for(input logic [ADDR_W-1:0] addr);
        rsp_t             r;
        logic [ADDR_W-3:0] idx;
        idx    = addr[ADDR_W-1:2];
        r.addr = addr;
        r.bad  = (idx >= DEPTH);
`ifdef IMEM_FAULT_EN
        if (addr[1:0] != 2'b00)
            r.bad = 1'b1;
`endif
        r.data = r.bad ? NOP : model[idx[6:0]];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data);
        load_we   = 1'b1;
        load_addr = addr;
        load_data = data;
        tick();
        load_we = 1'b0;
        if ((addr >> 2) < DEPTH)
            model[addr[8:2]] = data;
    endtask

    task automatic request(input logic [ADDR_W-1:0] addr);
        req_valid = 1'b1;
        req_addr  = addr;
        #1;
        chk($sformatf("req_ready@%0h", addr), req_ready, 1);
        sb.push_back(expect_for(addr));
    endtask

    task automatic check_head(input string tag);
        if (sb.size() == 0) begin
            chk({tag, "_sb_size"}, sb.size(), 1);
            return;
        end
        chk({tag, "_valid"}, rsp_valid, 1);
        chk({tag, "_addr"}, rsp_addr, sb[0].addr);
        chk({tag, "_data"}, rsp_data, sb[0].data);
`ifdef IMEM_FAULT_EN
        chk({tag, "_fault"}, rsp_fault, sb[0].bad);
`endif
    endtask

    task automatic pop();
        rsp_t d;
        if (sb.size() != 0)
            d = sb.pop_front();
    endtask

    initial begin
        rst = 1'b0; load_we = 1'b0; load_addr = '0; load_data = '0; load_done = 1'b0;
        req_valid = 1'b1; req_addr = '0; rsp_ready = 1'b0; flush = 1'b0;
        #3;
        chk("rst_running", running, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, NOP);
        chk("rst_rsp_addr", rsp_addr, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        chk("load_running", running, 0);
        chk("load_req_ready", req_ready, 0);
        chk("load_rsp_valid", rsp_valid, 0);
        req_valid = 1'b0;

        for (int i = 0; i < DEPTH; i++)
            load_word(ADDR_W'(i * 4), (i == 0) ? WORD0 : (i == 1) ? WORD1 : DATA_W'($urandom));
        load_word(ADDR_W'(4 * DEPTH), 22'h2AAAAA);
        chk("still_load", running, 0);
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        chk("run_running", running, 1);
        chk("run_req_ready", req_ready, 1);

        // back-to-back fetches
        rsp_ready = 1'b1;
        request(0);
        tick();
        check_head("b2b_0");
        pop();
        request(4);
        tick();
        check_head("b2b_4");
        pop();
        req_valid = 1'b0;
        tick();
        chk("retire_valid", rsp_valid, 0);
        chk("retire_data_kept", rsp_data, WORD1);

        // stall with a pending request behind it
        rsp_ready = 1'b0;
        request(8);
        tick();
        req_addr = 12;
        for (int k = 0; k < 3; k++) begin
            check_head($sformatf("stall%0d", k));
            chk($sformatf("stall%0d_req_ready", k), req_ready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        check_head("stall_release");
        pop();
        request(12);
        tick();
        check_head("after_stall_12");
        pop();
        req_valid = 1'b0;
        tick();
        chk("after_stall_retire", rsp_valid, 0);

        // flush with a simultaneous request
        rsp_ready = 1'b0;
        request(4);
        tick();
        check_head("held_4");
        flush = 1'b1;
        pop();
        request(20);
        tick();
        flush = 1'b0;
        req_valid = 1'b0;
        check_head("flush_new_20");
        rsp_ready = 1'b1;
        pop();
        tick();
        chk("flush_new_retire", rsp_valid, 0);

        // flush alone
        rsp_ready = 1'b0;
        request(8);
        tick();
        req_valid = 1'b0;
        flush = 1'b1;
        pop();
        tick();
        flush = 1'b0;
        chk("flush_alone_valid", rsp_valid, 0);

        // same-cycle load and fetch: read-before-write
        rsp_ready = 1'b1;
        load_we = 1'b1; load_addr = 12; load_data = 22'h3FFFFF;
        request(12);
        tick();
        load_we = 1'b0;
        model[3] = 22'h3FFFFF;
        check_head("rbw_old");
        pop();
        request(12);
        tick();
        check_head("rbw_new");
        pop();

        // out-of-range and misaligned fetches
        request(ADDR_W'(4 * DEPTH));
        tick();
        check_head("oor_512");
        pop();
        request(6);
        tick();
        check_head("misaligned_6");
        pop();
        req_valid = 1'b0;
        tick();

        // reset mid-operation
        request(0);
        tick();
        req_valid = 1'b0;
        check_head("pre_reset");
        pop();
        rst = 1'b0;
        #1;
        chk("midrst_rsp_valid", rsp_valid, 0);
        chk("midrst_running", running, 0);
        chk("midrst_req_ready", req_ready, 0);
        chk("midrst_rsp_addr", rsp_addr, 0);
        #4;
        rst = 1'b1;
        req_valid = 1'b1;
        req_addr  = 4;
        tick();
        chk("post_rst_no_fetch", req_ready, 0);
        chk("post_rst_rsp_valid", rsp_valid, 0);
        load_done = 1'b1;
        tick();
        load_done = 1'b0;
        request(4);
        tick();
        check_head("mem_kept_4");
        pop();
        req_valid = 1'b0;
        tick();
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
